// File: rtl/grey_readout.sv
// Reads three asynchronous Johnson-coded decimal digits. Waits for the inputs to settle, converts
// them to binary and hands the digits out one at a time over a valid/ready port.
module grey_readout #(
    parameter int unsigned pTIMEOUT = 64
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [4:0] i_100,
    input  logic [4:0] i_010,
    input  logic [4:0] i_001,
    input  logic       i_req,
    input  logic       i_ready,
    output logic       o_busy,
    output logic       o_valid,
    output logic [3:0] o_digit,
    output logic [1:0] o_pos,
    output logic [9:0] o_value,
    output logic [1:0] o_err,
    output logic       o_done
);

    localparam int unsigned TimerW = $clog2(pTIMEOUT + 1);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(pTIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StConvert, StEmit} state_e;

    // Returns {invalid, digit}; invalid codes read as digit 4'hF.
    function automatic logic [4:0] johnson_decode(input logic [4:0] code);
        logic [4:0] res;
        case (code)
            5'b00000: res = 5'd0;
            5'b00001: res = 5'd1;
            5'b00011: res = 5'd2;
            5'b00111: res = 5'd3;
            5'b01111: res = 5'd4;
            5'b11111: res = 5'd5;
            5'b11110: res = 5'd6;
            5'b11100: res = 5'd7;
            5'b11000: res = 5'd8;
            5'b10000: res = 5'd9;
            default:  res = 5'b11111;
        endcase
        return res;
    endfunction

    state_e            state_q, state_d;
    logic [14:0]       sync1_q, sync2_q, prev_q;
    logic [14:0]       snap_q, snap_d;
    logic [1:0]        stab_q, stab_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [9:0]        acc_q, acc_d;
    logic [9:0]        value_q, value_d;
    logic [1:0]        err_q, err_d;
    logic [1:0]        pos_q, pos_d;
    logic              done_q, done_d;

    logic [4:0]        digit_code;
    logic [4:0]        digit_dec;
    logic [9:0]        acc_times10;
    logic [9:0]        acc_next;

    // pos_q walks 2..0 both while converting and while emitting.
    always_comb begin
        case (pos_q)
            2'd2:    digit_code = snap_q[14:10];
            2'd1:    digit_code = snap_q[9:5];
            default: digit_code = snap_q[4:0];
        endcase
    end

    assign digit_dec   = johnson_decode(digit_code);
    assign acc_times10 = acc_q * 10'd10;
    assign acc_next    = acc_times10 + (digit_dec[4] ? 10'd0 : {6'd0, digit_dec[3:0]});

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        stab_d  = stab_q;
        timer_d = timer_q;
        acc_d   = acc_q;
        value_d = value_q;
        err_d   = err_q;
        pos_d   = pos_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_req) begin
                    state_d = StSettle;
                    stab_d  = 2'd0;
                    timer_d = '0;
                    err_d   = 2'b00;
                end
            end
            StSettle: begin
                timer_d = timer_q + TimerW'(1);
                if (stab_q == 2'd2) begin
                    // prev_q holds the word that matched on three consecutive samples
                    snap_d  = prev_q;
                    state_d = StConvert;
                    acc_d   = 10'd0;
                    pos_d   = 2'd2;
                end else if (timer_q == TimerLast) begin
                    snap_d   = sync2_q;
                    err_d[1] = 1'b1;
                    state_d  = StConvert;
                    acc_d    = 10'd0;
                    pos_d    = 2'd2;
                end else if (sync2_q == prev_q) begin
                    stab_d = stab_q + 2'd1;
                end else begin
                    stab_d = 2'd0;
                end
            end
            StConvert: begin
                acc_d = acc_next;
                if (digit_dec[4]) begin
                    err_d[0] = 1'b1;
                end
                if (pos_q == 2'd0) begin
                    value_d = acc_next;
                    state_d = StEmit;
                    pos_d   = 2'd2;
                end else begin
                    pos_d = pos_q - 2'd1;
                end
            end
            StEmit: begin
                if (i_ready) begin
                    if (pos_q == 2'd0) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        pos_d = pos_q - 2'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            snap_q  <= '0;
            stab_q  <= 2'd0;
            timer_q <= '0;
            acc_q   <= 10'd0;
            value_q <= 10'd0;
            err_q   <= 2'b00;
            pos_q   <= 2'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= {i_100, i_010, i_001};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            snap_q  <= snap_d;
            stab_q  <= stab_d;
            timer_q <= timer_d;
            acc_q   <= acc_d;
            value_q <= value_d;
            err_q   <= err_d;
            pos_q   <= pos_d;
            done_q  <= done_d;
        end
    end

    assign o_busy  = (state_q != StIdle);
    assign o_valid = (state_q == StEmit);
    assign o_digit = o_valid ? digit_dec[3:0] : 4'd0;
    assign o_pos   = o_valid ? pos_q : 2'd0;
    assign o_value = value_q;
    assign o_err   = err_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_grey_readout.sv
// Directed bench for grey_readout: table of readouts plus hand-written timeout and
// mid-transfer reset sequences.
module tb_grey_readout;

    logic       clk = 1'b0;
    logic       rst, req, ready;
    logic [4:0] h100, t010, o001;
    logic       busy, valid, done;
    logic [3:0] digit;
    logic [1:0] pos, err;
    logic [9:0] value;

    int         checks = 0;
    int         errors = 0;
    logic       toggle_en = 1'b0;
    logic [9:0] last_value = 10'd0;

    grey_readout #(.pTIMEOUT(64)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_100   (h100),
        .i_010   (t010),
        .i_001   (o001),
        .i_req   (req),
        .i_ready (ready),
        .o_busy  (busy),
        .o_valid (valid),
        .o_digit (digit),
        .o_pos   (pos),
        .o_value (value),
        .o_err   (err),
        .o_done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] h, t, o;
        int         stall_pos;
        logic [3:0] d2, d1, d0;
        logic [9:0] value;
        logic [1:0] err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; the ones digit optionally toggles every cycle.
    task automatic tick();
        @(negedge clk);
        if (toggle_en) o001 = o001 ^ 5'b00010;
    endtask

    task automatic run_readout(input logic [4:0] h, input logic [4:0] t, input logic [4:0] o,
                               input int stall_pos, input logic [3:0] d2, input logic [3:0] d1,
                               input logic [3:0] d0, input logic [9:0] exp_value,
                               input logic [1:0] exp_err, input int exp_lat, input logic tog);
        int         lat;
        int         p;
        logic [3:0] exp_d;
        h100 = h;
        t010 = t;
        o001 = o;
        ready = 1'b0;
        toggle_en = tog;
        repeat (4) tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        check("busy_in_settle", 32'(busy), 32'd1);
        check("value_held", 32'(value), 32'(last_value));
        lat = 0;
        while (!valid && lat < 200) begin
            tick();
            lat++;
        end
        check("latency_to_valid", 32'(lat), 32'(exp_lat));
        check("value", 32'(value), 32'(exp_value));
        check("err", 32'(err), 32'(exp_err));
        for (int k = 0; k < 3; k++) begin
            p = 2 - k;
            exp_d = (p == 2) ? d2 : (p == 1) ? d1 : d0;
            if (p == stall_pos) begin
                ready = 1'b0;
                req = 1'b1;
                repeat (5) begin
                    check("stall_valid", 32'(valid), 32'd1);
                    check("stall_pos", 32'(pos), 32'(p));
                    check("stall_digit", 32'(digit), 32'(exp_d));
                    tick();
                end
                req = 1'b0;
            end
            check("xfer_valid", 32'(valid), 32'd1);
            check("xfer_pos", 32'(pos), 32'(p));
            check("xfer_digit", 32'(digit), 32'(exp_d));
            check("done_early", 32'(done), 32'd0);
            ready = 1'b1;
            tick();
        end
        ready = 1'b0;
        check("valid_dropped", 32'(valid), 32'd0);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_after_done", 32'(busy), 32'd0);
        check("value_after_done", 32'(value), 32'(exp_value));
        check("err_after_done", 32'(err), 32'(exp_err));
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("still_idle", 32'(busy), 32'd0);
        toggle_en = 1'b0;
        last_value = exp_value;
    endtask

    vec_t vecs [8];

    initial begin
        int lat;
        vecs[0] = '{5'b00111, 5'b11100, 5'b10000, -1, 4'd3, 4'd7, 4'd9, 10'd379, 2'b00};
        vecs[1] = '{5'b00111, 5'b11100, 5'b10000,  1, 4'd3, 4'd7, 4'd9, 10'd379, 2'b00};
        vecs[2] = '{5'b00111, 5'b10101, 5'b10000, -1, 4'd3, 4'hF, 4'd9, 10'd309, 2'b01};
        vecs[3] = '{5'b10000, 5'b10000, 5'b10000, -1, 4'd9, 4'd9, 4'd9, 10'd999, 2'b00};
        vecs[4] = '{5'b00000, 5'b00000, 5'b00000, -1, 4'd0, 4'd0, 4'd0, 10'd0,   2'b00};
        vecs[5] = '{5'b11111, 5'b11110, 5'b00011,  0, 4'd5, 4'd6, 4'd2, 10'd562, 2'b00};
        vecs[6] = '{5'b01111, 5'b11000, 5'b00001,  2, 4'd4, 4'd8, 4'd1, 10'd481, 2'b00};
        vecs[7] = '{5'b00010, 5'b11000, 5'b11101, -1, 4'hF, 4'd8, 4'hF, 10'd80,  2'b01};

        // Reset with a simultaneous request: the request must be ignored.
        rst = 1'b1;
        req = 1'b1;
        ready = 1'b0;
        h100 = 5'b00111;
        t010 = 5'b11100;
        o001 = 5'b10000;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_digit", 32'(digit), 32'd0);
        check("rst_pos", 32'(pos), 32'd0);
        check("rst_value", 32'(value), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        req = 1'b0;
        tick();
        check("req_with_rst_ignored", 32'(busy), 32'd0);

        foreach (vecs[i]) begin
            run_readout(vecs[i].h, vecs[i].t, vecs[i].o, vecs[i].stall_pos, vecs[i].d2,
                        vecs[i].d1, vecs[i].d0, vecs[i].value, vecs[i].err, 6, 1'b0);
        end

        // Ones digit alternating 1/2 each cycle never settles; snapshot lands on digit 1.
        run_readout(5'b00111, 5'b11100, 5'b00001, -1, 4'd3, 4'd7, 4'd1, 10'd371, 2'b10, 67,
                    1'b1);

        // Reset in the middle of EMIT, with i_ready high on the reset edge.
        h100 = 5'b00111;
        t010 = 5'b11100;
        o001 = 5'b10000;
        repeat (4) tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        lat = 0;
        while (!valid && lat < 200) begin
            tick();
            lat++;
        end
        check("mid_emit_reach_valid", 32'(valid), 32'd1);
        ready = 1'b1;
        tick();
        check("mid_emit_pos1", 32'(pos), 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_value", 32'(value), 32'd0);
        check("mid_rst_digit", 32'(digit), 32'd0);
        rst = 1'b0;
        ready = 1'b0;
        tick();
        check("after_rst_no_xfer", 32'(valid), 32'd0);
        check("after_rst_no_done", 32'(done), 32'd0);
        last_value = 10'd0;
        run_readout(5'b00111, 5'b11100, 5'b10000, -1, 4'd3, 4'd7, 4'd9, 10'd379, 2'b00, 6, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/grey_readout.md
GREY_READOUT -- requirements
Module: grey_readout

Interface
REQ-001 SHALL have parameter pTIMEOUT, default 64, meaning the maximum number of i_clk cycles spent in SETTLE before the timeout fallback.
REQ-002 SHALL have these ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset; synchronous, active-high; clock i_clk.
- i_100  in  5  hundreds digit, 5-bit Johnson code, asynchronous to i_clk.
- i_010  in  5  tens digit, same encoding and timing as i_100.
- i_001  in  5  ones digit, same encoding and timing as i_100.
- i_req  in  1  start one readout.
- i_ready  in  1  consumer accepts o_digit.
- o_busy  out  1  high in every state except IDLE.
- o_valid  out  1  o_digit/o_pos are presented.
- o_digit  out  4  decoded digit; 4'hF when the code is invalid.
- o_pos  out  2  digit position: 2 = hundreds, 1 = tens, 0 = ones.
- o_value  out  10  binary value, 0..999.
- o_err  out  2  bit0 = invalid code seen, bit1 = settle timeout.
- o_done  out  1  one-cycle pulse when a readout completes.

Function
REQ-003 SHALL decode the Johnson code as follows; every other 5-bit code is invalid.

| Digit | Code  | Digit | Code  |
|-------|-------|-------|-------|
| 0     | 00000 | 5     | 11111 |
| 1     | 00001 | 6     | 11110 |
| 2     | 00011 | 7     | 11100 |
| 3     | 00111 | 8     | 11000 |
| 4     | 01111 | 9     | 10000 |

REQ-004 SHALL pass all 15 input bits through a two-flop synchronizer clocked by i_clk; no other logic SHALL observe the raw inputs.
REQ-005 SHALL implement the FSM states IDLE, SETTLE, CONVERT and EMIT.
REQ-006 IDLE: i_req=1 at an edge -> SETTLE on that edge; clear o_err and the stability counter.
REQ-007 i_req SHALL be ignored in every state other than IDLE.
REQ-008 SETTLE, stability test: each cycle compare the synchronized word with its value on the previous cycle.
- Equal: increment the stability count.
- Not equal: clear the stability count.
REQ-009 SETTLE, success: once the word has been equal for 3 consecutive samples (count = 2), load the snapshot register and go to CONVERT.
REQ-010 SETTLE, timeout: if pTIMEOUT cycles elapse in SETTLE without success:
- load the snapshot with the current synchronized word;
- set o_err[1];
- go to CONVERT.
REQ-011 CONVERT SHALL take exactly 3 cycles:
- clear an internal accumulator on entry;
- each cycle compute acc = acc*10 + d for d in order hundreds, tens, ones;
- use 10-bit unsigned arithmetic with no overflow possible.
REQ-012 An invalid digit SHALL contribute 0 to the accumulator and set o_err[0].
REQ-013 o_value SHALL update from the accumulator on the CONVERT->EMIT edge and hold until the next CONVERT completes.
REQ-014 EMIT SHALL present the digits in order pos 2, 1, 0 with o_valid=1.
REQ-015 A digit transfer SHALL occur on an edge with o_valid & i_ready; o_digit/o_pos SHALL hold stable until that transfer.
REQ-016 Transfer of pos 0 SHALL:
- drop o_valid;
- pulse o_done for one cycle;
- return the FSM to IDLE.
REQ-017 i_ready SHALL have no effect while o_valid=0.
REQ-018 o_err bits SHALL be sticky from being set until the next accepted i_req.
REQ-019 Minimum latency, in i_clk cycles:
- i_req accepted, then 3 cycles in SETTLE with stable synchronized inputs;
- then 3 cycles in CONVERT;
- first o_valid on the following cycle.

Reset
REQ-020 i_rst=1 at an edge SHALL:
- force IDLE;
- clear the synchronizer, snapshot, accumulator and counters;
- drive o_busy, o_valid, o_done, o_digit, o_pos, o_value and o_err to 0.
REQ-021 Reset in any state, including mid-EMIT, SHALL take effect on that edge with no partial transfer afterwards.
REQ-022 i_req asserted together with i_rst SHALL be ignored.

Verification
REQ-023 Static inputs (00111, 11100, 10000), i_req pulse, i_ready=1 -> transfers (pos 2, digit 3), (pos 1, digit 7), (pos 0, digit 9); o_value=379; o_err=0; one o_done pulse.
REQ-024 Same stimulus with i_ready held low for 5 cycles during pos 1 -> o_digit=7 and o_pos=1 stable for those 5 cycles; no transfer is skipped or duplicated.
REQ-025 Tens code 10101, other digits 3 and 9 -> pos 1 carries digit F; o_value=309; o_err=01.
REQ-026 Ones input toggling every i_clk cycle -> exit SETTLE after 64 cycles with o_err[1]=1; readout still completes.
REQ-027 Edge values -> 999 (10000 on all three digits) gives o_value=999; 000 gives o_value=0.
REQ-028 Reset asserted mid-EMIT -> o_valid=0 and o_busy=0 on the next cycle; a subsequent i_req runs a full readout.
